context_stack: RTL and testbench
================================

CONTEXT_STACK -- requirements
Module: context_stack

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of 240-bit register-context frames stored (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 push  input  1  request to save fc_save as a new frame; sampled only in IDLE.
REQ-005 pop  input  1  request to restore the most recent frame; sampled only in IDLE.
REQ-006 fc_save  input  240  context to save; word k = bits [16k+15:16k], k = 0..14; driven by the register file's fcOut.
REQ-007 fc_restore  output  240  frame most recently popped; same word layout; drives the register file's fcIn.
REQ-008 restore  output  1  one-cycle pulse; fc_restore is valid and stable; drives the register file's restore.
REQ-009 busy  output  1  high in PUSH, POP and ACK.
REQ-010 full  output  1  high when depth == DEPTH.
REQ-011 empty  output  1  high when depth == 0.
REQ-012 depth  output  5  number of frames stored, 0..DEPTH.
REQ-013 error  output  1  sticky overflow/underflow flag.

Function
REQ-014 Storage SHALL be a 16-bit word array of DEPTH*15 entries; frame f, word k SHALL be at address f*15+k.
REQ-015 The FSM SHALL have four states: IDLE, PUSH, POP and ACK; a 4-bit beat counter cnt SHALL count 0..14.
REQ-016 In IDLE, if push=1 and full=0, the block SHALL latch fc_save into a 240-bit shadow register, set cnt=0 and go to PUSH at the same edge.
REQ-017 In PUSH, one edge per beat SHALL write shadow word cnt to address depth*15+cnt; after beat 14 it SHALL increment depth and return to IDLE, for 15 cycles in PUSH.
REQ-018 In IDLE, if pop=1, push=0 and empty=0, the block SHALL set cnt=0 and go to POP.
REQ-019 In POP, one edge per beat SHALL load word (depth-1)*15+cnt into fc_restore word cnt; after beat 14 it SHALL decrement depth and go to ACK.
REQ-020 ACK SHALL last exactly one cycle with restore=1, then return to IDLE; restore SHALL be 0 in every other state.
REQ-021 Pop latency: accept edge E0; fc_restore complete after edge E15; restore high during the cycle after E15; busy low again after E16.
REQ-022 fc_restore SHALL hold its value from the end of a completed pop until the next pop's first beat; a partially updated value is allowed only during POP.
REQ-023 If push=1 and pop=1 together in IDLE, push SHALL win and pop SHALL be dropped without setting error.
REQ-024 If push=1 with full=1 in IDLE, the request SHALL be ignored, the block SHALL stay in IDLE, and error SHALL be set.
REQ-025 If pop=1 (with push=0) and empty=1 in IDLE, the request SHALL be ignored and error SHALL be set.
REQ-026 Requests while busy=1 SHALL be ignored, not queued, and SHALL NOT set error.
REQ-027 The shadow register SHALL make the pushed frame independent of fc_save changes after the accept edge.
REQ-028 full, empty and busy SHALL be decoded from registered state, with no combinational path from push or pop.

Reset
REQ-029 Reset SHALL force the FSM to IDLE and set cnt=0, depth=0, full=0, empty=1, busy=0, restore=0, error=0 and fc_restore=0, whether or not an operation is in progress.
REQ-030 Array contents SHALL NOT be required to clear on reset.
REQ-031 A reset during PUSH or POP SHALL abort the operation with depth=0, so no partial frame is counted.

Verification
REQ-032 Push F1 (word k = 16'h1000+k), then pop -> busy high for 15 cycles; later restore pulses once with fc_restore == F1; depth sequence 0->1->0.
REQ-033 Push F1, F2, F3, then pop three times -> restored frames in order F3, F2, F1; empty=1 at the end; error=0.
REQ-034 Push DEPTH frames, then push once more -> full=1, depth=DEPTH, error=1, FSM stays in IDLE; a following pop returns the last frame pushed.
REQ-035 Pop from reset -> error=1, restore never pulses, fc_restore==0; push+pop in the same IDLE cycle -> only the push happens, depth=1.
REQ-036 Change fc_save every cycle during PUSH -> a later pop returns the value captured at the accept edge; push and pop pulses while busy have no effect.
REQ-037 Assert reset_n=0 at beat 7 of a POP -> all outputs go to their reset values immediately (asynchronously); depth=0; no restore pulse.

Source files
------------

// File: rtl/context_stack.sv
// context_stack: LIFO of DEPTH 240-bit register-file contexts held as 16-bit words.
// Rev 1.0 - initial release.
`default_nettype none

module context_stack #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [239:0] fc_save,
  output logic [239:0] fc_restore,
  output logic         restore,
  output logic         busy,
  output logic         full,
  output logic         empty,
  output logic [4:0]   depth,
  output logic         error
);

  localparam int WORDS = 15;
  localparam int AW    = $clog2(DEPTH * WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [4:0]   depth_q, depth_d;
  logic [239:0] shadow_q, shadow_d;
  logic [239:0] fc_restore_q, fc_restore_d;
  logic         error_q, error_d;

  logic [15:0]   mem_q [DEPTH*WORDS];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_word;
  logic [15:0]   wr_word;

  // Push writes into the slot above the top frame; pop reads the top frame.
  assign wr_addr = AW'(depth_q) * AW'(WORDS) + AW'(cnt_q);
  assign rd_addr = AW'(depth_q - 5'd1) * AW'(WORDS) + AW'(cnt_q);
  assign rd_word = mem_q[rd_addr];
  assign wr_word = shadow_q[{cnt_q, 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (state_q == S_PUSH) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    depth_d      = depth_q;
    shadow_d     = shadow_q;
    fc_restore_d = fc_restore_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (push) begin
          if (!full) begin
            shadow_d = fc_save;
            cnt_d    = 4'd0;
            state_d  = S_PUSH;
          end else begin
            error_d = 1'b1;
          end
        end else if (pop) begin
          if (!empty) begin
            cnt_d   = 4'd0;
            state_d = S_POP;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_PUSH: begin
        if (cnt_q == 4'd14) begin
          depth_d = depth_q + 5'd1;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_POP: begin
        fc_restore_d[{cnt_q, 4'b0000} +: 16] = rd_word;
        if (cnt_q == 4'd14) begin
          depth_d = depth_q - 5'd1;
          cnt_d   = 4'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      depth_q      <= 5'd0;
      shadow_q     <= '0;
      fc_restore_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      depth_q      <= depth_d;
      shadow_q     <= shadow_d;
      fc_restore_q <= fc_restore_d;
      error_q      <= error_d;
    end
  end

  assign fc_restore = fc_restore_q;
  assign restore    = (state_q == S_ACK);
  assign busy       = (state_q != S_IDLE);
  assign full       = (depth_q == 5'(DEPTH));
  assign empty      = (depth_q == 5'd0);
  assign depth      = depth_q;
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_context_stack.sv
// tb_context_stack: vector table, corner sequences and random ops against a queue model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_context_stack;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         push;
  logic         pop;
  logic [239:0] fc_save;
  logic [239:0] fc_restore;
  logic         restore;
  logic         busy;
  logic         full;
  logic         empty;
  logic [4:0]   depth;
  logic         error;

  int checks = 0;
  int errors = 0;

  context_stack #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .fc_save    (fc_save),
    .fc_restore (fc_restore),
    .restore    (restore),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .depth      (depth),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit p;
    bit q;
    int fid;
    int exp_busy;
    int exp_pulse;
    int exp_fid;
    int exp_depth;
    bit exp_err;
  } vec_t;

  function automatic logic [239:0] frame(input int n);
    logic [239:0] f;
    for (int k = 0; k < 15; k++) f[k*16 +: 16] = 16'(n * 4096 + k);
    return f;
  endfunction

  function automatic logic [239:0] rand240();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[239:0];
  endfunction

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input int d, input bit e);
    chk({tag, ".depth"}, 240'(depth), 240'(d));
    chk({tag, ".full"}, 240'(full), 240'(d == DEPTH));
    chk({tag, ".empty"}, 240'(empty), 240'(d == 0));
    chk({tag, ".busy"}, 240'(busy), 240'(0));
    chk({tag, ".restore"}, 240'(restore), 240'(0));
    chk({tag, ".error"}, 240'(error), 240'(e));
  endtask

  // Issue one request, then let the operation run while throwing stray
  // requests and fc_save noise at the busy block.
  task automatic op(input bit p, input bit q, input logic [239:0] f,
                    output int nbusy, output int npulse, output logic [239:0] rcap);
    int guard;
    push = p; pop = q; fc_save = f;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; fc_save = rand240();
    nbusy = 0; npulse = 0; rcap = '0; guard = 0;
    while (busy && guard < 40) begin
      nbusy++;
      if (restore) begin
        npulse++;
        rcap = fc_restore;
      end
      push = 1'($urandom_range(0, 1));
      pop = 1'($urandom_range(0, 1));
      fc_save = rand240();
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
      guard++;
    end
    if (guard >= 40) begin
      checks++; errors++;
      $display("FAIL timeout: busy still %0b after %0d cycles, required 0", busy, guard);
    end
  endtask

  task automatic do_op_check(input string tag, input bit p, input bit q, input logic [239:0] f,
                             input int exp_busy, input int exp_pulse, input logic [239:0] exp_frame,
                             input int exp_depth, input bit exp_err);
    int nb, np;
    logic [239:0] rc;
    op(p, q, f, nb, np, rc);
    chk({tag, ".busy_cycles"}, 240'(nb), 240'(exp_busy));
    chk({tag, ".pulses"}, 240'(np), 240'(exp_pulse));
    if (exp_pulse != 0) chk({tag, ".frame"}, rc, exp_frame);
    check_status(tag, exp_depth, exp_err);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    logic [239:0] stk[$];
    logic [239:0] last_rst;
    logic [239:0] f;
    bit merr;
    int np;

    reset_n = 1'b0; push = 1'b0; pop = 1'b0; fc_save = '0;
    do_reset();
    check_status("reset", 0, 1'b0);
    chk("reset.fc_restore", fc_restore, '0);

    tbl[0]  = '{1'b1, 1'b0, 1, 15, 0, 0, 1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 0, 16, 1, 1, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1, 15, 0, 0, 1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2, 15, 0, 0, 2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3, 15, 0, 0, 3, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 0, 16, 1, 3, 2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 0, 16, 1, 2, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 0, 16, 1, 1, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4, 15, 0, 0, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 0, 16, 1, 4, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      do_op_check($sformatf("vec%0d", i), tbl[i].p, tbl[i].q, frame(tbl[i].fid),
                  tbl[i].exp_busy, tbl[i].exp_pulse, frame(tbl[i].exp_fid),
                  tbl[i].exp_depth, tbl[i].exp_err);
    end
    chk("vec.hold", fc_restore, frame(4));

    // Fill to capacity, overflow once, then pop the top frame.
    for (int n = 1; n <= DEPTH; n++)
      do_op_check($sformatf("fill%0d", n), 1'b1, 1'b0, frame(n), 15, 0, '0, n, 1'b0);
    do_op_check("overflow", 1'b1, 1'b0, frame(DEPTH + 1), 0, 0, '0, DEPTH, 1'b1);
    do_op_check("pop_top", 1'b0, 1'b1, '0, 16, 1, frame(DEPTH), DEPTH - 1, 1'b1);

    do_reset();
    do_op_check("underflow", 1'b0, 1'b1, '0, 0, 0, '0, 0, 1'b1);
    chk("underflow.fc_restore", fc_restore, '0);

    // Asynchronous reset at beat 7 of a pop.
    do_reset();
    do_op_check("r_pop.push", 1'b1, 1'b0, frame(5), 15, 0, '0, 1, 1'b0);
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("r_pop.busy", 240'(busy), 240'(0));
    chk("r_pop.restore", 240'(restore), 240'(0));
    chk("r_pop.depth", 240'(depth), 240'(0));
    chk("r_pop.empty", 240'(empty), 240'(1));
    chk("r_pop.full", 240'(full), 240'(0));
    chk("r_pop.error", 240'(error), 240'(0));
    chk("r_pop.fc_restore", fc_restore, '0);
    @(posedge clk); #3 reset_n = 1'b1;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (restore) np++;
    end
    chk("r_pop.no_pulse", 240'(np), 240'(0));
    check_status("r_pop.after", 0, 1'b0);

    // Reset during a push leaves no partial frame behind.
    push = 1'b1; fc_save = frame(6);
    @(posedge clk); #1;
    push = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("r_push.depth", 240'(depth), 240'(0));
    chk("r_push.busy", 240'(busy), 240'(0));
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    do_op_check("r_push.pop", 1'b0, 1'b1, '0, 0, 0, '0, 0, 1'b1);

    // Random operations against a queue model of the stack.
    do_reset();
    stk.delete();
    merr = 1'b0;
    last_rst = '0;
    for (int i = 0; i < 60; i++) begin
      int r;
      int eb, ep;
      logic [239:0] ef;
      bit p, q;
      r = $urandom_range(0, 7);
      p = (r < 3) || (r == 6);
      q = (r >= 3 && r < 6) || (r == 6);
      f = rand240();
      eb = 0; ep = 0; ef = '0;
      if (p) begin
        if (stk.size() < DEPTH) begin
          stk.push_back(f);
          eb = 15;
        end else merr = 1'b1;
      end else if (q) begin
        if (stk.size() > 0) begin
          ef = stk.pop_back();
          last_rst = ef;
          eb = 16; ep = 1;
        end else merr = 1'b1;
      end
      do_op_check($sformatf("rnd%0d", i), p, q, f, eb, ep, ef, stk.size(), merr);
      chk($sformatf("rnd%0d.hold", i), fc_restore, last_rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
